// File: rtl/decoder_4x16_seq.sv
// Registered 4-to-16 one-hot decoder with valid/ready intake and a timed hold/gap pulse.
// Optional code parity checking is enabled by defining CODE_PARITY_EN.
module decoder_4x16_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in,
    output logic [15:0] out,
    output logic        out_valid,
    output logic        busy
`ifdef CODE_PARITY_EN
    ,
    input  logic        in_par,
    output logic        par_err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [15:0]        out_r;
    logic               out_valid_r;
    logic               busy_r;

`ifdef CODE_PARITY_EN
    logic               par_err_r;

    // Even parity over code plus parity bit must reduce to zero.
    function automatic logic code_parity_ok(input logic [3:0] code, input logic par);
        return (^{code, par}) == 1'b0;
    endfunction

    assign par_err = par_err_r;
`endif

    assign in_ready  = (state_r == IDLE);
    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

    // Hold/gap sequencer; the code is latched into out_r at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            out_r       <= 16'h0000;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef CODE_PARITY_EN
            par_err_r   <= 1'b0;
`endif
        end else begin
`ifdef CODE_PARITY_EN
            par_err_r <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
`ifdef CODE_PARITY_EN
                        if (!code_parity_ok(in, in_par)) begin
                            par_err_r <= 1'b1;
                        end else
`endif
                        begin
                            out_r       <= 16'h0001 << in;
                            out_valid_r <= 1'b1;
                            busy_r      <= 1'b1;
                            cnt_r       <= CNT_W'(HOLD_CYCLES - 1);
                            state_r     <= DRIVE;
                        end
                    end
                end
                DRIVE: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        out_r       <= 16'h0000;
                        out_valid_r <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            cnt_r   <= CNT_W'(GAP_CYCLES - 1);
                            state_r <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    out_r       <= 16'h0000;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_4x16_seq.sv
// Self-checking bench for decoder_4x16_seq: default instance (HOLD=4, GAP=1) and a fast one (HOLD=1, GAP=0),
// compared each cycle against a pulse-timing model keyed on the accept cycle.
module tb_decoder_4x16_seq;

`ifdef CODE_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int HA = 4, GA = 1, HB = 1, GB = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv_a = 1'b0, iv_b = 1'b0;
    logic [3:0]  in_a = 4'd0, in_b = 4'd0;
    logic        par_a = 1'b0, par_b = 1'b0;
    logic        rdy_a, rdy_b, ov_a, ov_b, busy_a, busy_b;
    logic [15:0] out_a, out_b;
    logic        perr_a_o, perr_b_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit has_a = 1'b0, has_b = 1'b0;
    int acc_a = 0, acc_b = 0, perr_a = -100;
    logic [3:0] code_a = 4'd0, code_b = 4'd0;

    always #5 clk = ~clk;

    decoder_4x16_seq u_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(rdy_a), .in(in_a),
        .out(out_a), .out_valid(ov_a), .busy(busy_a)
`ifdef CODE_PARITY_EN
        , .in_par(par_a), .par_err(perr_a_o)
`endif
    );

    decoder_4x16_seq #(.HOLD_CYCLES(HB), .GAP_CYCLES(GB), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(rdy_b), .in(in_b),
        .out(out_b), .out_valid(ov_b), .busy(busy_b)
`ifdef CODE_PARITY_EN
        , .in_par(par_b), .par_err(perr_b_o)
`endif
    );

`ifndef CODE_PARITY_EN
    assign perr_a_o = 1'b0;
    assign perr_b_o = 1'b0;
`endif

    // A pulse accepted at edge acc is visible after edges acc..acc+hold-1; idle again from acc+hold+gap.
    function automatic logic [15:0] exp_out(bit has, int age, logic [3:0] code, int hold);
        logic [15:0] one;
        one = 16'h0001;
        if (has && age >= 0 && age < hold) return one << code;
        return 16'h0000;
    endfunction

    function automatic bit exp_rdy(bit has, int age, int hold, int gap);
        return !has || age >= hold + gap;
    endfunction

    task automatic tick();
        bit ra, rb;
        ra = exp_rdy(has_a, cyc - acc_a, HA, GA);
        rb = exp_rdy(has_b, cyc - acc_b, HB, GB);
        @(posedge clk);
        cyc++;
        if (iv_a && ra) begin
            if (PAR_EN && (^{in_a, par_a})) perr_a = cyc;
            else begin has_a = 1'b1; acc_a = cyc; code_a = in_a; end
        end
        if (iv_b && rb) begin has_b = 1'b1; acc_b = cyc; code_b = in_b; end
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (out_a !== 16'h0000 || ov_a !== 1'b0 || busy_a !== 1'b0 || rdy_a !== 1'b1 || perr_a_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_initial: out=%h ov=%b busy=%b rdy=%b perr=%b, required 0000/0/0/1/0",
                     out_a, ov_a, busy_a, rdy_a, perr_a_o);
        end
        @(negedge clk) rst = 1'b0;
        tick();
        iv_a = 1'b1; in_a = 4'd5; par_a = ^4'd5;
        tick();
        iv_a = 1'b0;
        tick();
        n_cmp++;
        if (out_a !== 16'h0020 || busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL reset_predrive: out=%h busy=%b, required 0020/1", out_a, busy_a);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_a !== 16'h0000 || ov_a !== 1'b0 || busy_a !== 1'b0 || rdy_a !== 1'b1) begin
            n_err++;
            $display("FAIL reset_middrive: out=%h ov=%b busy=%b rdy=%b, required 0000/0/0/1",
                     out_a, ov_a, busy_a, rdy_a);
        end
        has_a = 1'b0; has_b = 1'b0; perr_a = -100;
        @(negedge clk) rst = 1'b0;
        tick();
    endtask

    task automatic test_all_codes();
        logic [15:0] eo;
        bit er;
        int hi;
        for (int c = 0; c < 16; c++) begin
            iv_a = 1'b1; in_a = 4'(c); par_a = ^in_a;
            tick();
            iv_a = 1'b0;
            hi = 0;
            for (int k = 0; k < HA + GA + 1; k++) begin
                eo = exp_out(has_a, cyc - acc_a, code_a, HA);
                er = exp_rdy(has_a, cyc - acc_a, HA, GA);
                if (out_a !== 16'h0000) hi++;
                n_cmp++;
                if (out_a !== eo || ov_a !== (eo != 16'h0000) || busy_a !== !er || rdy_a !== er) begin
                    n_err++;
                    $display("FAIL all_codes c=%0d k=%0d: out=%h ov=%b busy=%b rdy=%b, required %h/%b/%b/%b",
                             c, k, out_a, ov_a, busy_a, rdy_a, eo, eo != 16'h0000, !er, er);
                end
                if (k < HA + GA) tick();
            end
            n_cmp++;
            if (hi != HA) begin
                n_err++;
                $display("FAIL pulse_len c=%0d: got %0d cycles, required %0d", c, hi, HA);
            end
        end
    endtask

    task automatic test_handshake();
        logic [15:0] eo;
        bit er;
        iv_a = 1'b1; in_a = 4'd3; par_a = ^4'd3;
        tick();
        in_a = 4'd9; par_a = ^4'd9;
        for (int k = 0; k < 12; k++) begin
            eo = exp_out(has_a, cyc - acc_a, code_a, HA);
            er = exp_rdy(has_a, cyc - acc_a, HA, GA);
            n_cmp++;
            if (out_a !== eo || ov_a !== (eo != 16'h0000) || busy_a !== !er || rdy_a !== er) begin
                n_err++;
                $display("FAIL handshake k=%0d: out=%h ov=%b busy=%b rdy=%b, required %h/%b/%b/%b",
                         k, out_a, ov_a, busy_a, rdy_a, eo, eo != 16'h0000, !er, er);
            end
            if (k < 4) begin
                n_cmp++;
                if (out_a !== 16'h0008) begin
                    n_err++;
                    $display("FAIL handshake_latch k=%0d: out=%h, required 0008", k, out_a);
                end
            end
            tick();
        end
        iv_a = 1'b0;
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq_exp [4];
        logic [15:0] eo;
        seq_exp = '{16'h0080, 16'h0000, 16'h0100, 16'h0000};
        iv_b = 1'b1; in_b = 4'd7; par_b = ^4'd7;
        tick();
        in_b = 4'd8; par_b = ^4'd8;
        for (int k = 0; k < 4; k++) begin
            eo = exp_out(has_b, cyc - acc_b, code_b, HB);
            n_cmp++;
            if (out_b !== seq_exp[k] || out_b !== eo || ov_b !== (eo != 16'h0000)) begin
                n_err++;
                $display("FAIL back_to_back k=%0d: out=%h ov=%b, required %h/%b",
                         k, out_b, ov_b, seq_exp[k], seq_exp[k] != 16'h0000);
            end
            if (k == 2) iv_b = 1'b0;
            tick();
        end
    endtask

    task automatic test_random();
        logic [15:0] eo;
        bit er;
        for (int k = 0; k < 300; k++) begin
            iv_a = 1'($urandom_range(0, 1)); in_a = 4'($urandom_range(0, 15)); par_a = ^in_a;
            if (PAR_EN && $urandom_range(0, 7) == 0) par_a = ~par_a;
            iv_b = 1'($urandom_range(0, 1)); in_b = 4'($urandom_range(0, 15)); par_b = ^in_b;
            tick();
            eo = exp_out(has_a, cyc - acc_a, code_a, HA);
            er = exp_rdy(has_a, cyc - acc_a, HA, GA);
            n_cmp++;
            if (out_a !== eo || ov_a !== (eo != 16'h0000) || busy_a !== !er || rdy_a !== er
                || perr_a_o !== (PAR_EN && perr_a == cyc)) begin
                n_err++;
                $display("FAIL random_a k=%0d: out=%h ov=%b busy=%b rdy=%b perr=%b, required %h/%b/%b/%b/%b",
                         k, out_a, ov_a, busy_a, rdy_a, perr_a_o, eo, eo != 16'h0000, !er, er,
                         PAR_EN && perr_a == cyc);
            end
            eo = exp_out(has_b, cyc - acc_b, code_b, HB);
            er = exp_rdy(has_b, cyc - acc_b, HB, GB);
            n_cmp++;
            if (out_b !== eo || ov_b !== (eo != 16'h0000) || busy_b !== !er || rdy_b !== er) begin
                n_err++;
                $display("FAIL random_b k=%0d: out=%h ov=%b busy=%b rdy=%b, required %h/%b/%b/%b",
                         k, out_b, ov_b, busy_b, rdy_b, eo, eo != 16'h0000, !er, er);
            end
        end
        iv_a = 1'b0; iv_b = 1'b0;
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic test_parity();
        iv_a = 1'b1; in_a = 4'b0111; par_a = 1'b0;
        tick();
        iv_a = 1'b0;
        n_cmp++;
        if (perr_a_o !== 1'b1 || out_a !== 16'h0000 || rdy_a !== 1'b1) begin
            n_err++;
            $display("FAIL parity_bad: perr=%b out=%h rdy=%b, required 1/0000/1", perr_a_o, out_a, rdy_a);
        end
        tick();
        n_cmp++;
        if (perr_a_o !== 1'b0 || out_a !== 16'h0000) begin
            n_err++;
            $display("FAIL parity_pulse: perr=%b out=%h, required 0/0000", perr_a_o, out_a);
        end
        iv_a = 1'b1; in_a = 4'b0111; par_a = 1'b1;
        tick();
        iv_a = 1'b0;
        n_cmp++;
        if (perr_a_o !== 1'b0 || out_a !== 16'h0080) begin
            n_err++;
            $display("FAIL parity_good: perr=%b out=%h, required 0/0080", perr_a_o, out_a);
        end
        for (int k = 0; k < 8; k++) tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_all_codes();
        test_handshake();
        test_back_to_back();
        if (PAR_EN) test_parity();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
